// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake and data-memory port bundle for the load/store initiator.
// slave = initiator side, master = execute stage plus memory side.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [2:0]  mem_MemSrc;
    logic [31:0] mem_RD;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_RD,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE, mem_MemSrc
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_RD,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE, mem_MemSrc
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one registered memory cycle per request, sign-extended load data.
// Latency: accept at edge N, MEM in cycle N+1, response from cycle N+2 (errors skip MEM).
// Backpressure: req_ready low until the response handshakes; MISALIGN_TRAP_EN traps misaligned H/W.
module lsu_mem_initiator #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_mem_initiator_if.slave   bus,
    output logic [CNT_WIDTH-1:0] access_count
);

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t     state;
    logic       we_q;
    logic [2:0] funct3_q;
    logic       illegal;
    logic       misalign;

    always_comb begin
        illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
        misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Memory already zero-extends by size; only the signed forms need work here.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] rd);
        case (f3)
            3'b000:  load_ext = {{24{rd[7]}}, rd[7:0]};
            3'b001:  load_ext = {{16{rd[15]}}, rd[15:0]};
            default: load_ext = rd;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.mem_WE     <= 1'b0;
            bus.mem_A      <= 32'd0;
            bus.mem_WD     <= 32'd0;
            bus.mem_MemSrc <= 3'd0;
            access_count   <= '0;
            we_q           <= 1'b0;
            funct3_q       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        we_q          <= bus.req_we;
                        funct3_q      <= bus.req_funct3;
                        if (illegal || misalign) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                        end else begin
                            state          <= MEM;
                            bus.mem_A      <= bus.req_addr;
                            bus.mem_WD     <= bus.req_wdata;
                            bus.mem_WE     <= bus.req_we;
                            bus.mem_MemSrc <= bus.req_funct3;
                        end
                    end
                end
                MEM: begin
                    state          <= RESP;
                    bus.mem_WE     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= we_q ? 32'd0 : load_ext(funct3_q, bus.mem_RD);
                    access_count   <= access_count + 1'b1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte-array memory model and a response scoreboard.
module tb_lsu_mem_initiator;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] access_count;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  mem[0:1023];

    lsu_mem_initiator_if bus();

    lsu_mem_initiator #(.CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .access_count (access_count)
    );

    always #5 clk = ~clk;

    // Memory model: combinational zero-extended read, write commits on the edge where WE=1.
    always_comb begin
        case (bus.mem_MemSrc[1:0])
            2'b00:   bus.mem_RD = {24'd0, mem[bus.mem_A[9:0]]};
            2'b01:   bus.mem_RD = {16'd0, mem[bus.mem_A[9:0] + 10'd1], mem[bus.mem_A[9:0]]};
            default: bus.mem_RD = {mem[bus.mem_A[9:0] + 10'd3], mem[bus.mem_A[9:0] + 10'd2],
                                   mem[bus.mem_A[9:0] + 10'd1], mem[bus.mem_A[9:0]]};
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_WE) begin
            mem[bus.mem_A[9:0]] <= bus.mem_WD[7:0];
            if (bus.mem_MemSrc[1:0] != 2'b00)
                mem[bus.mem_A[9:0] + 10'd1] <= bus.mem_WD[15:8];
            if (bus.mem_MemSrc[1:0] == 2'b10) begin
                mem[bus.mem_A[9:0] + 10'd2] <= bus.mem_WD[23:16];
                mem[bus.mem_A[9:0] + 10'd3] <= bus.mem_WD[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request until accepted; returns one cycle after the accept edge.
    task automatic start_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        int t = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        while (bus.req_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int hold);
        int          cyc;
        int          we_cyc;
        logic [32:0] e;
        exp_q.push_back({exp_err, exp_rd});
        start_req(we, f3, a, wd);
        cyc    = 1;
        we_cyc = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 20) begin
            if (bus.mem_WE) we_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        if (!exp_err) check("latency", cyc, 32'd2);
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b0;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h300;
            if (bus.mem_WE) we_cyc++;
            @(posedge clk); #1;
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_rdata", bus.resp_rdata, e[31:0]);
            check("hold_err", {31'd0, bus.resp_err}, {31'd0, e[32]});
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        check("rdata", bus.resp_rdata, e[31:0]);
        check("err", {31'd0, bus.resp_err}, {31'd0, e[32]});
        if (bus.mem_WE) we_cyc++;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("we_cycles", we_cyc, (we && !exp_err) ? 32'd1 : 32'd0);
        check("ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("valid_after", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_WE", {31'd0, bus.mem_WE}, 32'd0);
        check("rst_mem_A", bus.mem_A, 32'd0);
        check("rst_mem_WD", bus.mem_WD, 32'd0);
        check("rst_mem_MemSrc", {29'd0, bus.mem_MemSrc}, 32'd0);
        check("rst_count", {16'd0, access_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store then load
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        check("count_sw_lw", {16'd0, access_count}, 32'd2);

        // Sign / zero extension of bytes and halfwords
        do_req(1'b1, 3'b000, 32'h10, 32'h00000080, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        do_req(1'b0, 3'b100, 32'h10, 32'h0, 32'h00000080, 1'b0, 0);
        do_req(1'b1, 3'b001, 32'h20, 32'h00008001, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF8001, 1'b0, 0);
        do_req(1'b0, 3'b101, 32'h20, 32'h0, 32'h00008001, 1'b0, 0);
        check("count_ext", {16'd0, access_count}, 32'd8);

        // Response backpressure
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 5);
        check("count_bp", {16'd0, access_count}, 32'd9);

        // Illegal encodings: no memory effect, counter unchanged
        do_req(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 0);
        do_req(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 2);
        do_req(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 0);
        check("count_illegal", {16'd0, access_count}, 32'd9);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Misaligned accesses
        do_req(1'b1, 3'b010, 32'h104, 32'h11223344, 32'h0, 1'b0, 0);
        do_req(1'b0, 3'b010, 32'h102, 32'h0, TRAP ? 32'h0 : 32'h3344DEAD, TRAP, 0);
        do_req(1'b0, 3'b001, 32'h101, 32'h0, TRAP ? 32'h0 : 32'hFFFFADBE, TRAP, 0);
        check("count_misalign", {16'd0, access_count}, TRAP ? 32'd11 : 32'd13);

        // Reset while a load response is pending
        start_req(1'b0, 3'b010, 32'h100, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_resp_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_count", {16'd0, access_count}, 32'd0);

        // Reset during the MEM cycle of a store: the write still lands
        start_req(1'b1, 3'b010, 32'h200, 32'h12345678);
        check("mem_cycle_WE", {31'd0, bus.mem_WE}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mem_WE_low", {31'd0, bus.mem_WE}, 32'd0);
        check("rst_mem_req_ready", {31'd0, bus.req_ready}, 32'd1);
        do_req(1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0, 0);
        check("count_after_rst", {16'd0, access_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
